pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Parameters
REQ-001 WIDTH, default 16: width of the program counter and of all address ports.
REQ-002 RESET_VEC, default 0: PC value loaded on reset.
REQ-003 STEP, default 1: increment applied on sequential advance.
REQ-004 RAS_DEPTH, default 4 (power of two, >=2): entries in the return-address stack.

Interface
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 hlt  in  1  halt request; PC freezes and unit enters HALTED.
REQ-008 stall  in  1  hold PC and RAS for this cycle.
REQ-009 br_taken  in  1  redirect PC to br_tgt.
REQ-010 br_tgt  in  WIDTH  branch/jump/call target.
REQ-011 call  in  1  redirect to br_tgt and push pc+STEP onto the RAS.
REQ-012 ret  in  1  redirect to the popped RAS top.
REQ-013 pc  out  WIDTH  registered current PC.
REQ-014 pc_inc  out  WIDTH  combinational pc+STEP, modulo 2^WIDTH.
REQ-015 halted  out  1  high while in HALTED.
REQ-016 ras_empty / ras_full  out  1 each  RAS occupancy flags (combinational from count).
REQ-017 ras_err  out  1  sticky: RAS overflow or underflow has occurred.

Function
REQ-018 The unit has two states, RUN and HALTED; RUN->HALTED on a rising edge with hlt=1; HALTED is left only by reset.
REQ-019 In HALTED, pc, the RAS and ras_err hold regardless of every other input.
REQ-020 In RUN, next-pc priority per edge: hlt (hold) > stall (hold) > ret > call > br_taken > sequential (pc+STEP).
REQ-021 On the hlt edge, pc holds its current value and no RAS operation occurs.
REQ-022 Stall holds pc and the RAS unchanged; redirect inputs seen during stall are discarded, not queued.
REQ-023 Redirect latency: target appears on pc one cycle after the edge on which it is sampled.
REQ-024 Sequential advance wraps modulo 2^WIDTH (e.g. 16'hFFFF+1 -> 16'h0000); no flag.
REQ-025 call pushes the old pc_inc and loads br_tgt in the same edge; count increments by 1.
REQ-026 Push when full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_err set.
REQ-027 ret on non-empty RAS: pc <= top entry, count decrements by 1.
REQ-028 ret on empty RAS: pc <= pc_inc, count stays 0, ras_err set.
REQ-029 ret and call in the same cycle: only ret acts (no push); br_taken ignored whenever ret or call is high.
REQ-030 ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
REQ-031 All arithmetic unsigned, WIDTH bits, carry discarded.

Reset
REQ-032 rst_n low asynchronously forces pc=RESET_VEC, state=RUN, RAS count=0, ras_err=0, halted=0, regardless of clk.
REQ-033 RAS entry contents are not required to be reset; they are unobservable when count=0.
REQ-034 Reset asserted mid-stall, mid-halt or mid-call overrides everything; first post-reset edge with no controls yields pc=RESET_VEC+STEP.

Verification
REQ-035 Reset release, 5 idle edges (defaults) -> pc 0,1,2,3,4,5; halted=0, ras_empty=1.
REQ-036 pc=16'hFFFE, 3 idle edges -> 16'hFFFF, 16'h0000, 16'h0001.
REQ-037 pc=10: call br_tgt=100, idle, idle, ret -> pc 100,101,102,11; ras_empty=1 at end, ras_err=0.
REQ-038 5 consecutive calls (RAS_DEPTH=4) then 5 rets -> ras_full after 4th call; ras_err=1 after 5th call; first 4 rets return the 4 most recent return addresses, 5th ret yields pc_inc.
REQ-039 pc=20: stall+br_taken(tgt=50) one cycle, then hlt -> pc 20,20 then held forever, halted=1; async rst_n pulse mid-cycle -> pc=0 immediately, halted=0.
REQ-040 call and ret same edge with RAS holding 40 -> pc=40, count decrements, no push.

Source files
------------

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter with branch/call/return redirect and a circular
// return-address stack (RAS).
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   hlt        in   halt request; PC freezes and the unit enters HALTED
//   stall      in   hold PC and RAS for this cycle (redirects are dropped)
//   br_taken   in   redirect PC to br_tgt
//   br_tgt     in   branch / jump / call target
//   call       in   redirect to br_tgt and push pc+STEP onto the RAS
//   ret        in   redirect to the popped RAS top
//   pc         out  registered current PC
//   pc_inc     out  combinational pc+STEP (wraps modulo 2^WIDTH)
//   halted     out  high while in HALTED
//   ras_empty  out  RAS holds no entries
//   ras_full   out  RAS holds RAS_DEPTH entries
//   ras_err    out  sticky RAS overflow / underflow indication
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      STEP      = 1,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hlt,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_tgt,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    // One extra bit so the count can represent "full" (== RAS_DEPTH).
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   sp_q, sp_d;     // next free slot; top entry is sp_q-1
    logic               err_q, err_d;
    logic               push;
    logic [PTR_W-1:0]   top_ptr;
    logic [WIDTH-1:0]   ras_mem [RAS_DEPTH];

    assign pc_inc  = pc_q + STEP_W;     // carry discarded
    // Depth is a power of two, so the pointer wraps naturally.
    assign top_ptr = sp_q - PTR_W'(1);

    // -------------------------------------------------------------------------
    // Next-state logic. Priority in RUN: hlt > stall > ret > call > br_taken >
    // sequential. A push onto a full stack lands on sp_q, which in that case is
    // exactly the oldest entry, giving the circular overwrite for free.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and a latch is never inferred.
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;

        if (state_q == ST_RUN) begin
            if (hlt) begin
                state_d = ST_HALTED;
            end else if (stall) begin
                // hold everything; redirects this cycle are dropped
            end else if (ret) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_mem[top_ptr];
                    cnt_d = cnt_q - CNT_W'(1);
                    sp_d  = top_ptr;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else if (call) begin
                push = 1'b1;
                pc_d = br_tgt;
                sp_d = sp_q + PTR_W'(1);
                if (cnt_q == FULL_CNT) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (br_taken) begin
                pc_d = br_tgt;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            cnt_q   <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // NOTE: stack storage is deliberately not reset; entries are invisible
    // while the count is zero, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[sp_q] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALTED);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);
    assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit with default
// parameters (WIDTH=16, RESET_VEC=0, STEP=1, RAS_DEPTH=4).
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        hlt;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_tgt;
    logic        call;
    logic        ret;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        halted;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int n_tests;
    int n_fail;

    pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hlt       (hlt),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_tgt    (br_tgt),
        .call      (call),
        .ret       (ret),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .halted    (halted),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drop every control input to its idle value.
    task automatic idle_inputs();
        hlt      = 1'b0;
        stall    = 1'b0;
        br_taken = 1'b0;
        br_tgt   = '0;
        call     = 1'b0;
        ret      = 1'b0;
    endtask

    // One rising edge, then settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [15:0] tgt);
        idle_inputs();
        br_taken = 1'b1;
        br_tgt   = tgt;
        step();
        idle_inputs();
    endtask

    task automatic do_call(input logic [15:0] tgt);
        idle_inputs();
        call   = 1'b1;
        br_tgt = tgt;
        step();
        idle_inputs();
    endtask

    task automatic do_ret();
        idle_inputs();
        ret = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    logic [15:0] ret_exp [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;

        // Reset state.
        check("rst_pc",        pc,        16'h0000);
        check("rst_halted",    halted,    16'h0);
        check("rst_ras_empty", ras_empty, 16'h1);
        check("rst_ras_full",  ras_full,  16'h0);
        check("rst_ras_err",   ras_err,   16'h0);

        // Release away from the edge, then 5 idle edges: 1..5.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("seq_pc%0d", i), pc, 16'(i));
        end
        check("seq_pc_inc",  pc_inc,    16'd6);
        check("seq_halted",  halted,    16'h0);
        check("seq_empty",   ras_empty, 16'h1);

        // Wrap-around: FFFE -> FFFF -> 0000 -> 0001.
        do_branch(16'hFFFE);
        check("wrap_br",  pc,     16'hFFFE);
        step();
        check("wrap_ff",  pc,     16'hFFFF);
        check("wrap_inc", pc_inc, 16'h0000);
        step();
        check("wrap_0",   pc,     16'h0000);
        step();
        check("wrap_1",   pc,     16'h0001);

        // Simple call / return.
        do_branch(16'd10);
        check("cr_start", pc, 16'd10);
        do_call(16'd100);
        check("cr_call",  pc,        16'd100);
        check("cr_nemp",  ras_empty, 16'h0);
        step();
        check("cr_101",   pc, 16'd101);
        step();
        check("cr_102",   pc, 16'd102);
        do_ret();
        check("cr_ret",   pc,        16'd11);
        check("cr_empty", ras_empty, 16'h1);
        check("cr_err",   ras_err,   16'h0);

        // Stall drops a call and a branch; RAS untouched.
        call = 1'b1; br_taken = 1'b1; br_tgt = 16'd500; stall = 1'b1;
        step();
        idle_inputs();
        check("stall_pc",    pc,        16'd11);
        check("stall_empty", ras_empty, 16'h1);
        step();
        check("stall_after", pc,        16'd12);

        // call wins over br_taken.
        call = 1'b1; br_taken = 1'b1; br_tgt = 16'd39;
        step();
        idle_inputs();
        check("call_prio_pc",  pc,        16'd39);
        check("call_prio_ras", ras_empty, 16'h0);
        do_ret();
        check("call_prio_ret", pc,        16'd13);

        // call and ret together with RAS holding 40: only ret acts.
        do_branch(16'd39);
        do_call(16'd200);
        check("cr2_call", pc, 16'd200);
        call = 1'b1; ret = 1'b1; br_taken = 1'b1; br_tgt = 16'd300;
        step();
        idle_inputs();
        check("cr2_pc",    pc,        16'd40);
        check("cr2_empty", ras_empty, 16'h1);
        check("cr2_err",   ras_err,   16'h0);

        // Overflow and underflow with depth 4.
        do_branch(16'd1000);
        for (int i = 0; i < 5; i++) begin
            do_call(16'(2000 + 1000 * i));
            check($sformatf("ovf_call%0d", i), pc, 16'(2000 + 1000 * i));
            if (i == 3) begin
                check("ovf_full4", ras_full, 16'h1);
                check("ovf_err4",  ras_err,  16'h0);
            end
        end
        check("ovf_full5", ras_full, 16'h1);
        check("ovf_err5",  ras_err,  16'h1);
        ret_exp[0] = 16'd5001;
        ret_exp[1] = 16'd4001;
        ret_exp[2] = 16'd3001;
        ret_exp[3] = 16'd2001;
        ret_exp[4] = 16'd2002;  // empty stack -> pc_inc
        for (int i = 0; i < 5; i++) begin
            do_ret();
            check($sformatf("ovf_ret%0d", i), pc, ret_exp[i]);
        end
        check("udf_empty", ras_empty, 16'h1);
        check("udf_err",   ras_err,   16'h1);

        // Reset clears the sticky error; then stall + halt sequence.
        reset_pulse();
        check("err_clr", ras_err, 16'h0);
        check("err_pc",  pc,      16'h0000);
        do_branch(16'd20);
        check("h_start", pc, 16'd20);
        stall = 1'b1; br_taken = 1'b1; br_tgt = 16'd50;
        step();
        idle_inputs();
        check("h_stall", pc, 16'd20);
        hlt = 1'b1;
        step();
        check("h_pc",     pc,     16'd20);
        check("h_halted", halted, 16'h1);
        // Everything is ignored while halted, including hlt dropping.
        hlt = 1'b0; ret = 1'b1; br_taken = 1'b1; br_tgt = 16'd77;
        step();
        call = 1'b1; ret = 1'b0;
        step();
        idle_inputs();
        step();
        check("h_hold_pc",  pc,        16'd20);
        check("h_hold_hlt", halted,    16'h1);
        check("h_hold_err", ras_err,   16'h0);
        check("h_hold_ras", ras_empty, 16'h1);

        // Asynchronous reset mid-cycle takes effect without an edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pc",     pc,     16'h0000);
        check("async_halted", halted, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_pc", pc, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
